// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the ALU and its round-robin arbiter:
// word/opcode widths, opcode encoding and response slot states.
package alu_rr_arbiter_pkg;

  localparam int WORD_W = 16;
  localparam int OP_W   = 5;

  // Opcode encoding shared with the external ALU.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_INVF = 5'd1,
    OP_ADDF = 5'd2,
    OP_MULF = 5'd3,
    OP_AND  = 5'd4,
    OP_OR   = 5'd5,
    OP_XOR  = 5'd6,
    OP_ANY  = 5'd7,
    OP_DUP  = 5'd8,
    OP_SHR  = 5'd9,
    OP_F2I  = 5'd10,
    OP_I2F  = 5'd11
  } alu_op_e;

  // One-entry response register occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/alu_rr_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
// Ports: enable, valid0/valid1, last_gnt in; grant_valid, grant_id out.
module rr_pick2 (
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  input  logic last_gnt,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (enable) begin
      unique case ({valid1, valid0})
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        2'b11: begin
          // Tie: the one not served last time wins.
          grant_valid = 1'b1;
          grant_id    = ~last_gnt;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Ports: req0/req1 valid/ready + op/a/b, ALU drive and result,
// tagged response valid/ready/id/result, saturating grant counters.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int OPW   = OP_W,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [CNTW-1:0]  gnt_cnt0,
  output logic [CNTW-1:0]  gnt_cnt1
);

  localparam logic [CNTW-1:0] CNT_ONE = 1;

  slot_e            state;
  slot_e            state_nxt;
  logic             slot_free;
  logic             pick_en;
  logic             gnt_valid;
  logic             gnt_id;
  logic             gnt0;
  logic             gnt1;
  logic             last_gnt;
  logic             id_q;
  logic [WIDTH-1:0] res_q;
  logic [CNTW-1:0]  cnt0_q;
  logic [CNTW-1:0]  cnt1_q;

  // A drain and a capture may share one edge.
  assign slot_free = (state == SLOT_EMPTY) | rsp_ready;
  // Reset blocks acceptance in the reset cycle itself.
  assign pick_en   = slot_free & ~reset;

  rr_pick2 u_pick (
    .enable      (pick_en),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_gnt    (last_gnt),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  assign gnt0       = gnt_valid & ~gnt_id;
  assign gnt1       = gnt_valid & gnt_id;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // ALU drive: idle cycles present add 0+0.
  always_comb begin
    alu_op  = '0;
    alu_in1 = '0;
    alu_in2 = '0;
    unique case (1'b1)
      gnt0: begin
        alu_op  = req0_op;
        alu_in1 = req0_a;
        alu_in2 = req0_b;
      end
      gnt1: begin
        alu_op  = req1_op;
        alu_in1 = req1_a;
        alu_in2 = req1_b;
      end
      default: begin
        alu_op  = '0;
        alu_in1 = '0;
        alu_in2 = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (gnt_valid) begin
      state_nxt = SLOT_FULL;
    end else if (state == SLOT_FULL && rsp_ready) begin
      state_nxt = SLOT_EMPTY;
    end
  end

  always_comb begin
    rsp_valid = (state == SLOT_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q    <= '0;
      id_q     <= 1'b0;
      last_gnt <= 1'b1;
    end else if (gnt_valid) begin
      res_q    <= alu_result;
      id_q     <= gnt_id;
      last_gnt <= gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && !(&cnt0_q)) begin
        cnt0_q <= cnt0_q + CNT_ONE;
      end
      if (gnt1 && !(&cnt1_q)) begin
        cnt1_q <= cnt1_q + CNT_ONE;
      end
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign gnt_cnt0   = cnt0_q;
  assign gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter with a behavioural ALU
// and a transaction-level model of the arbiter.
module tb_alu_rr_arbiter;

  localparam int W  = 16;
  localparam int OW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [OW-1:0] req0_op = '0;
  logic [W-1:0]  req0_a = '0;
  logic [W-1:0]  req0_b = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [OW-1:0] req1_op = '0;
  logic [W-1:0]  req1_a = '0;
  logic [W-1:0]  req1_b = '0;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_in1;
  logic [W-1:0]  alu_in2;
  logic [W-1:0]  alu_result;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [W-1:0]  rsp_result;
  logic [CW-1:0] gnt_cnt0;
  logic [CW-1:0] gnt_cnt1;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  bit          m_full = 0;
  bit          m_id = 0;
  logic [W-1:0] m_res = '0;
  bit          m_last = 1;
  int          m_c0 = 0;
  int          m_c1 = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.WIDTH(W), .OPW(OW), .CNTW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  function automatic logic [W-1:0] i2f(input logic [W-1:0] v);
    int e;
    logic [W-1:0] m;
    if (v == '0) return '0;
    e = 15;
    while (!v[e]) e--;
    m = v << (15 - e);
    return {1'b0, 8'(127 + e), m[14:8]};
  endfunction

  // Behavioural stand-in for the external ALU.
  function automatic logic [W-1:0] alu_fn(input logic [OW-1:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      5'd0:    return a + b;
      5'd4:    return a & b;
      5'd5:    return a | b;
      5'd6:    return a ^ b;
      5'd9:    return a >> b[3:0];
      5'd11:   return i2f(a);
      default: return a;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op, alu_in1, alu_in2);

  // Expected grant from the arbitration rules.
  task automatic pick(output bit gv, output bit gid);
    bit free;
    free = !m_full || rsp_ready;
    gv = 0;
    gid = 0;
    if (!reset && free) begin
      if (req0_valid && req1_valid) begin
        gv = 1;
        gid = !m_last;
      end else if (req0_valid) begin
        gv = 1;
      end else if (req1_valid) begin
        gv = 1;
        gid = 1;
      end
    end
  endtask

  // Advance one clock edge and update the model.
  task automatic adv();
    bit gv, gid;
    logic [W-1:0] r;
    pick(gv, gid);
    r = gid ? alu_fn(req1_op, req1_a, req1_b)
            : alu_fn(req0_op, req0_a, req0_b);
    @(posedge clk);
    if (reset) begin
      m_full = 0; m_id = 0; m_res = '0;
      m_last = 1; m_c0 = 0; m_c1 = 0;
    end else if (gv) begin
      m_res = r; m_id = gid; m_full = 1; m_last = gid;
      if (gid) m_c1 = (m_c1 < CMAX) ? m_c1 + 1 : CMAX;
      else     m_c0 = (m_c0 < CMAX) ? m_c0 + 1 : CMAX;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; rsp_ready = 1;
    req0_valid = 1; req0_op = 0; req0_a = 16'h3; req0_b = 16'h4;
    #2;
    n_vec++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    n_vec++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
    adv();
    reset = 0; req0_valid = 0;
    #2;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL rst_id: got %b want 0", rsp_id); end
    n_vec++; if (rsp_result !== 16'h0) begin n_bad++; $display("FAIL rst_result: got %h want 0000", rsp_result); end
    n_vec++; if (gnt_cnt0 !== 4'h0) begin n_bad++; $display("FAIL rst_cnt0: got %h want 0", gnt_cnt0); end
    n_vec++; if (gnt_cnt1 !== 4'h0) begin n_bad++; $display("FAIL rst_cnt1: got %h want 0", gnt_cnt1); end
    adv();
  endtask

  task automatic test_single();
    req0_valid = 1; req0_op = 0; req0_a = 16'h3; req0_b = 16'h4;
    rsp_ready = 1;
    #2;
    n_vec++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", req0_ready); end
    n_vec++; if (alu_in1 !== 16'h3) begin n_bad++; $display("FAIL single_in1: got %h want 0003", alu_in1); end
    adv();
    req0_valid = 0;
    #2;
    n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    n_vec++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL single_id: got %b want 0", rsp_id); end
    n_vec++; if (rsp_result !== 16'h7) begin n_bad++; $display("FAIL single_result: got %h want 0007", rsp_result); end
    n_vec++; if (gnt_cnt0 !== 4'h1) begin n_bad++; $display("FAIL single_cnt0: got %h want 1", gnt_cnt0); end
    adv();
  endtask

  task automatic test_tie();
    logic [W-1:0] want;
    reset = 1; adv(); reset = 0;
    rsp_ready = 1;
    req0_valid = 1; req0_op = 4; req0_a = 16'h00F0; req0_b = 16'h0F0F;
    req1_valid = 1; req1_op = 6; req1_a = 16'h00FF; req1_b = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_vec++; if (req0_ready !== (i % 2 == 0)) begin n_bad++; $display("FAIL tie_ready0[%0d]: got %b want %b", i, req0_ready, i % 2 == 0); end
      n_vec++; if (req1_ready !== (i % 2 == 1)) begin n_bad++; $display("FAIL tie_ready1[%0d]: got %b want %b", i, req1_ready, i % 2 == 1); end
      if (i > 0) begin
        want = (i % 2 == 1) ? 16'h0000 : 16'h00FE;
        n_vec++; if (rsp_result !== want || rsp_id !== ((i - 1) % 2 == 1)) begin n_bad++; $display("FAIL tie_rsp[%0d]: got %h/%b want %h/%b", i, rsp_result, rsp_id, want, (i - 1) % 2 == 1); end
      end
      adv();
    end
    req0_valid = 0; req1_valid = 0;
    #2;
    n_vec++; if (rsp_result !== 16'h00FE || rsp_id !== 1'b1) begin n_bad++; $display("FAIL tie_last: got %h/%b want 00fe/1", rsp_result, rsp_id); end
    adv();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1;
    req0_valid = 1; req0_op = 0; req0_a = 16'h1; req0_b = 16'h1;
    #2; adv();
    req0_valid = 0;
    req1_valid = 1; req1_op = 0; req1_a = 16'h10; req1_b = 16'h20;
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_vec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready); end
      n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h2 || rsp_id !== 1'b0) begin n_bad++; $display("FAIL bp_hold[%0d]: got %b/%h/%b want 1/0002/0", i, rsp_valid, rsp_result, rsp_id); end
      adv();
    end
    rsp_ready = 1;
    #2;
    n_vec++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", req1_ready); end
    adv();
    req1_valid = 0;
    #2;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h30 || rsp_id !== 1'b1) begin n_bad++; $display("FAIL bp_new: got %b/%h/%b want 1/0030/1", rsp_valid, rsp_result, rsp_id); end
    adv();
  endtask

  task automatic test_float();
    rsp_ready = 1;
    req1_valid = 1; req1_op = 11; req1_a = 16'h0001; req1_b = 16'h0;
    #2;
    n_vec++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL f_ready: got %b want 1", req1_ready); end
    adv();
    req1_valid = 0; rsp_ready = 0;
    #2;
    n_vec++; if (rsp_result !== 16'h3F80 || rsp_id !== 1'b1) begin n_bad++; $display("FAIL f_result: got %h/%b want 3f80/1", rsp_result, rsp_id); end
    adv();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 0;
    req0_valid = 1; req0_op = 0; req0_a = 16'h5; req0_b = 16'h5;
    reset = 1;
    #2;
    n_vec++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL rm_ready: got %b want 0", req0_ready); end
    n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rm_full: got %b want 1", rsp_valid); end
    adv();
    reset = 0; rsp_ready = 1;
    req1_valid = 1; req1_op = 0; req1_a = 16'h1; req1_b = 16'h2;
    #2;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", rsp_valid); end
    n_vec++; if (gnt_cnt0 !== 4'h0 || gnt_cnt1 !== 4'h0) begin n_bad++; $display("FAIL rm_cnt: got %h/%h want 0/0", gnt_cnt0, gnt_cnt1); end
    n_vec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_bad++; $display("FAIL rm_tie: got %b%b want 10", req0_ready, req1_ready); end
    adv();
    req0_valid = 0; req1_valid = 0;
    #2; adv();
  endtask

  task automatic test_saturation();
    int want;
    reset = 1; adv(); reset = 0;
    rsp_ready = 1;
    req0_valid = 1; req0_op = 0; req0_a = 16'h1; req0_b = 16'h1;
    for (int i = 0; i < 20; i++) begin
      adv();
      want = (i + 1 < CMAX) ? i + 1 : CMAX;
      n_vec++; if (int'(gnt_cnt0) != want) begin n_bad++; $display("FAIL sat_cnt0[%0d]: got %0d want %0d", i, gnt_cnt0, want); end
      n_vec++; if (gnt_cnt1 !== 4'h0) begin n_bad++; $display("FAIL sat_cnt1[%0d]: got %0d want 0", i, gnt_cnt1); end
    end
    req0_valid = 0;
    adv();
  endtask

  task automatic test_random();
    bit gv, gid, e0, e1, acc0, acc1;
    logic [OW-1:0] eop;
    logic [W-1:0] ein1, ein2;
    reset = 1; req0_valid = 0; req1_valid = 0; adv(); reset = 0;
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!(req0_valid && !acc0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = 5'($urandom_range(0, 15));
        req0_a = 16'($urandom); req0_b = 16'($urandom);
      end
      if (!(req1_valid && !acc1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = 5'($urandom_range(0, 15));
        req1_a = 16'($urandom); req1_b = 16'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #2;
      pick(gv, gid);
      e0 = gv && !gid;
      e1 = gv && gid;
      eop = e0 ? req0_op : e1 ? req1_op : '0;
      ein1 = e0 ? req0_a : e1 ? req1_a : '0;
      ein2 = e0 ? req0_b : e1 ? req1_b : '0;
      n_vec++; if (req0_ready !== e0 || req1_ready !== e1) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready, e0, e1); end
      n_vec++; if (alu_op !== eop || alu_in1 !== ein1 || alu_in2 !== ein2) begin n_bad++; $display("FAIL rnd_alu[%0d]: got %h/%h/%h want %h/%h/%h", i, alu_op, alu_in1, alu_in2, eop, ein1, ein2); end
      n_vec++; if (rsp_valid !== m_full) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, rsp_valid, m_full); end
      n_vec++; if (rsp_id !== m_id || rsp_result !== m_res) begin n_bad++; $display("FAIL rnd_rsp[%0d]: got %b/%h want %b/%h", i, rsp_id, rsp_result, m_id, m_res); end
      n_vec++; if (int'(gnt_cnt0) != m_c0 || int'(gnt_cnt1) != m_c1) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, gnt_cnt0, gnt_cnt1, m_c0, m_c1); end
      acc0 = e0;
      acc1 = e1;
      adv();
    end
    reset = 0; req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_float();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
